dma_stream_fifo: RTL
====================

// Module: dma_stream_fifo
// PURPOSE
//  Parametrised valid/ready FIFO for DMA read-to-write data staging; successor to the DMA count-based FIFO.
//  Adds a stream handshake, optional fall-through bypass, synchronous flush, runtime watermarks,
//  fill-level output and a peak-level statistic for DMA burst tuning. Sits between the DMA read
//  engine (producer) and the write engine (consumer).
// PARAMETERS
//  DATA_WIDTH    32  payload width in bits
//  DEPTH         16  entries; power of 2, >= 2 (elaboration-time assertion)
//  FALL_THROUGH  0   0: registered, 1-cycle first-word latency; 1: empty FIFO forwards input same cycle
//  LVL_W         $clog2(DEPTH)+1  level/threshold width (derived localparam, not overridable)
// PORTS
//  clk_i          in   1           clock
//  rst_ni         in   1           asynchronous reset, active-low
//  flush_i        in   1           synchronous flush: discard all entries
//  in_valid_i     in   1           producer has data
//  in_ready_o     out  1           FIFO accepts data
//  in_data_i      in   DATA_WIDTH  write payload
//  out_valid_o    out  1           head data available
//  out_ready_i    in   1           consumer takes head
//  out_data_o     out  DATA_WIDTH  head payload
//  af_thr_i       in   LVL_W       almost-full threshold
//  ae_thr_i       in   LVL_W       almost-empty threshold
//  level_o        out  LVL_W       current number of stored entries
//  almost_full_o  out  1           level_o >= af_thr_i
//  almost_empty_o out  1           level_o <= ae_thr_i
//  max_level_o    out  LVL_W       highest level_o since reset or last stat_clr_i
//  stat_clr_i     in   1           reload max_level_o
// BEHAVIOUR
//  - push = in_valid_i & in_ready_o; pop = out_valid_o & out_ready_i.
//  - in_ready_o = (level_q != DEPTH) & ~flush_i. When full, in_ready_o stays 0 even if a pop occurs
//    that cycle (no ready->ready combinational path).
//  - FALL_THROUGH=0: out_valid_o = (level_q != 0) & ~flush_i; out_data_o = mem[rd_ptr_q].
//    A word pushed in cycle N is visible at the output in cycle N+1.
//  - FALL_THROUGH=1: when level_q == 0, out_valid_o = in_valid_i & ~flush_i and out_data_o = in_data_i.
//    Push+pop while empty is a bypass: no memory write, no pointer or level change.
//    Upstream must hold in_data_i stable while in_valid_i & ~in_ready_o.
//  - Head data is stable while out_valid_o & ~out_ready_i (storage path).
//  - Pointers: PTR_W = LVL_W-1 bits; they wrap naturally from DEPTH-1 to 0. level_q is LVL_W bits,
//    range 0..DEPTH.
//  - level_d:
//    - push only: +1.
//    - pop only: -1.
//    - push & pop: unchanged; legal when full for pop only, since push is blocked.
//    - neither: unchanged.
//  - flush_i: suppresses push and pop in the same cycle. The next cycle has wr_ptr = rd_ptr = level = 0.
//    Memory contents are not cleared. max_level_o is unaffected.
//  - almost_full_o and almost_empty_o are combinational from level_q and the threshold ports.
//    af_thr_i = 0 forces almost_full_o = 1. ae_thr_i >= DEPTH forces almost_empty_o = 1.
//  - max_level_q updates every cycle to max(max_level_q, level_d).
//    stat_clr_i loads level_d instead; it has priority over the max update.
//  - Reset: pointers, level_q and max_level_q are 0; memory is not reset.
//    Outputs at reset (flush_i=0):
//    - in_ready_o = 1, level_o = 0, max_level_o = 0, almost_empty_o = 1.
//    - out_valid_o = 0 (FALL_THROUGH=0) or in_valid_i (FALL_THROUGH=1).
//    - almost_full_o = (af_thr_i == 0).
//  - Reset mid-burst: contents are discarded and no stale word is presented after reset release.
// TESTING
//  T1 Fill/drain (DEPTH=16, FT=0): push 0x100..0x10F back-to-back, out_ready=0.
//     -> level 16, in_ready=0, max_level 16. Then drain -> data in order, level 0, out_valid=0.
//  T2 Full + simultaneous: at level 16, assert in_valid and out_ready for 1 cycle.
//     -> pop only, level 15, the pushed word is not accepted. Next cycle push and pop together -> level stays 15.
//  T3 Wrap: 40 random push/pop cycles, random stalls, scoreboard.
//     -> exact order preserved across pointer wrap; level always matches the model.
//  T4 Fall-through (FT=1): empty FIFO, in_valid=1, in_data=0xCAFE, out_ready=1.
//     -> out_valid=1 and out_data=0xCAFE in the same cycle; level stays 0. FT=0 same stimulus -> appears 1 cycle later.
//  T5 Flush: level 9, pulse flush_i with in_valid=out_ready=1.
//     -> in_ready=out_valid=0 that cycle; next cycle level=0 and max_level stays 9. stat_clr -> max_level=0.
//  T6 Watermarks: af_thr=12, ae_thr=3; sweep level 0..16.
//     -> almost_full exactly when level>=12, almost_empty exactly when level<=3. Async reset at level 7 -> level 0, out_valid 0.

Source files
------------

// File: rtl/dma_stream_fifo.sv
// dma_stream_fifo: valid/ready staging FIFO between the DMA read and write engines,
// with optional fall-through, synchronous flush, watermarks and a peak-level statistic.
module dma_stream_fifo #(
    parameter int DATA_WIDTH   = 32,
    parameter int DEPTH        = 16,
    parameter bit FALL_THROUGH = 1'b0,
    localparam int LVL_W       = $clog2(DEPTH) + 1
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  flush_i,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic [DATA_WIDTH-1:0] in_data_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [DATA_WIDTH-1:0] out_data_o,
    input  logic [LVL_W-1:0]      af_thr_i,
    input  logic [LVL_W-1:0]      ae_thr_i,
    output logic [LVL_W-1:0]      level_o,
    output logic                  almost_full_o,
    output logic                  almost_empty_o,
    output logic [LVL_W-1:0]      max_level_o,
    input  logic                  stat_clr_i
);
    localparam int PTR_W = LVL_W - 1;

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("dma_stream_fifo: DEPTH must be a power of 2 and at least 2");
    end

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]      level_q, level_d, max_level_q, max_level_d;
    logic                  empty, ft_empty, push, pop, bypass, wr_en, rd_en;

    // Handshake, fall-through forwarding and next-state computation.
    // A full FIFO never raises in_ready_o on a same-cycle pop, so ready does not
    // depend combinationally on out_ready_i.
    always_comb begin
        empty          = level_q == '0;
        ft_empty       = FALL_THROUGH && empty;
        in_ready_o     = (level_q != LVL_W'(DEPTH)) && !flush_i;
        out_valid_o    = ft_empty ? (in_valid_i && !flush_i) : (!empty && !flush_i);
        out_data_o     = ft_empty ? in_data_i : mem_q[rd_ptr_q];
        push           = in_valid_i && in_ready_o;
        pop            = out_valid_o && out_ready_i;
        bypass         = ft_empty && push && pop;
        wr_en          = push && !bypass;
        rd_en          = pop && !bypass;
        wr_ptr_d       = flush_i ? '0 : wr_ptr_q + PTR_W'(wr_en);
        rd_ptr_d       = flush_i ? '0 : rd_ptr_q + PTR_W'(rd_en);
        level_d        = flush_i ? '0 : level_q + LVL_W'(wr_en) - LVL_W'(rd_en);
        max_level_d    = stat_clr_i ? level_d : (level_d > max_level_q ? level_d : max_level_q);
        level_o        = level_q;
        max_level_o    = max_level_q;
        almost_full_o  = level_q >= af_thr_i;
        almost_empty_o = level_q <= ae_thr_i;
    end

    // Pointer, level and peak-statistic state; the level returning to zero on reset
    // is what keeps stale storage from being presented afterwards.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            max_level_q <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            max_level_q <= max_level_d;
        end
    end

    // Storage array; contents are deliberately left unreset.
    always_ff @(posedge clk_i) begin
        if (wr_en) mem_q[wr_ptr_q] <= in_data_i;
    end
endmodule
